morse_rx_ctrl: RTL and testbench
================================

MORSE_RX_CTRL -- requirements
Module: morse_rx_ctrl

Interface
REQ-001 Parameter DEBOUNCE_MS, default 10, key level must hold this many ticks before acceptance.
REQ-002 Parameter DOT_MAX_MS, default 300, press of fewer ticks is dot, otherwise dash.
REQ-003 Parameter GAP_MS, default 1000, release of this many ticks ends a character.
REQ-004 clk  in  1  system clock, single domain.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 tick_1ms  in  1  one-clk enable pulse every 1 ms, the only timebase.
REQ-007 key  in  1  raw button level, 0 = pressed, asynchronous.
REQ-008 sym_valid  out  1  one-clk pulse per accepted symbol.
REQ-009 sym_long  out  1  class of the symbol, valid with sym_valid (1 = dash).
REQ-010 char_valid  out  1  one-clk pulse per completed character.
REQ-011 char_code  out  8  ASCII result, held until the next char_valid.
REQ-012 char_err  out  1  set with char_valid when char_code is 8'h3F.
REQ-013 disp_buf  out  24  last three characters; newest in [7:0], oldest in [23:16].

Function
REQ-014 key shall pass a 2-flop synchronizer before any use.
REQ-015 Debounced level shall change only after the synchronized key differs from it for DEBOUNCE_MS consecutive ticks; any mismatch-free tick resets the count.
REQ-016 FSM states: IDLE, PRESS, GAP, OVF.
REQ-017 IDLE: on debounced press -> PRESS, press counter cleared.
REQ-018 PRESS: press counter increments per tick, saturates at DOT_MAX_MS.
REQ-019 PRESS on debounced release: pulse sym_valid, with sym_long = (count >= DOT_MAX_MS); append the symbol; clear the gap counter; go to GAP, or to OVF if 5 symbols are already held.
REQ-020 GAP: gap counter increments per tick, saturates at GAP_MS; press before GAP_MS -> PRESS with no character emitted.
REQ-021 GAP on gap counter reaching GAP_MS: pulse char_valid on the next clk; update char_code and disp_buf; clear the symbol register; go to IDLE.
REQ-022 OVF: ignore presses; GAP_MS ticks of continuous release -> emit 8'h3F with char_err=1, then IDLE; any press restarts the gap count.
REQ-023 Symbols shall be held in a 5-bit shift register plus a 3-bit count 0..5, first symbol in the MSB position.
REQ-024 Decode, exactly 5 symbols (dot=., dash=-):
- ----- = 0
- .---- = 1
- ..--- = 2
- ...-- = 3
- ....- = 4
- ..... = 5
- -.... = 6
- --... = 7
- ---.. = 8
- ----. = 9
- Output is ASCII 8'h30 to 8'h39.
REQ-025 Any other pattern or count shall give 8'h3F with char_err=1.
REQ-026 disp_buf update shall be {disp_buf[15:0], char_code}, the same clk as char_valid.
REQ-027 sym_valid and char_valid shall never assert in the same clk.
REQ-028 A press and release inside one debounce window shall produce no symbol.
REQ-029 In IDLE, release has no timeout and never emits a character.

Reset
REQ-030 rst_n low shall asynchronously clear:
- FSM to IDLE
- all counters and the symbol register
- sym_valid, sym_long, char_valid, char_err to 0
- char_code to 8'h20
- disp_buf to 24'h202020
- debounced level to released (1)
REQ-031 Reset mid-character shall discard partial symbols with no output pulse.
REQ-032 Release of reset shall be synchronous to clk through a 2-flop reset synchronizer.

Structure
REQ-033 A shared package (morse_pkg) shall hold the FSM state encoding, ASCII constants (CH_ZERO=8'h30, CH_ERR=8'h3F, CH_BLANK=8'h20) and the decode table function.
REQ-034 Debounce shall be a separate sub-module, key_debounce (sync plus counter, one output level).

Verification
REQ-035 Key sequence 5 presses of 100 ms, each followed by 200 ms release, then 1200 ms release -> 5 sym_valid with sym_long=0; char_code=8'h35; disp_buf[7:0]=8'h35.
REQ-036 Key sequence dot then 4 dashes of 500 ms, then gap -> char_code=8'h31, char_err=0; second character "0" -> disp_buf[15:0]=16'h3130.
REQ-037 Key sequence 3 presses, then gap -> char_code=8'h3F, char_err=1.
REQ-038 Key sequence 6 presses with a 7th press during OVF -> a single 8'h3F, emitted only after a full 1000 ms quiet period.
REQ-039 Key glitch 5 ms low -> no sym_valid; rst_n pulsed after 2 symbols -> no char_valid; a following "9" decodes cleanly.
REQ-040 Press of exactly 299 ms -> dot; press of exactly 300 ms -> dash.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse digit receiver: FSM encoding, ASCII constants
// and the five-symbol digit decode table.
package morse_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_OVF   = 2'd3;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_ERR   = 8'h3F;
    localparam logic [7:0] CH_BLANK = 8'h20;

    localparam logic [2:0] SYM_MAX  = 3'd5;

    typedef struct packed {
        logic [7:0] code;
        logic       err;
    } char_dec_t;

    // syms holds dash=1 / dot=0 with the first symbol in bit 4.
    function automatic char_dec_t decode_char(input logic [4:0] syms, input logic [2:0] cnt);
        char_dec_t res;
        res.code = CH_ERR;
        res.err  = 1'b1;
        if (cnt == SYM_MAX) begin
            res.err = 1'b0;
            case (syms)
                5'b11111: res.code = CH_ZERO;
                5'b01111: res.code = CH_ZERO + 8'd1;
                5'b00111: res.code = CH_ZERO + 8'd2;
                5'b00011: res.code = CH_ZERO + 8'd3;
                5'b00001: res.code = CH_ZERO + 8'd4;
                5'b00000: res.code = CH_ZERO + 8'd5;
                5'b10000: res.code = CH_ZERO + 8'd6;
                5'b11000: res.code = CH_ZERO + 8'd7;
                5'b11100: res.code = CH_ZERO + 8'd8;
                5'b11110: res.code = CH_ZERO + 8'd9;
                default: begin
                    res.code = CH_ERR;
                    res.err  = 1'b1;
                end
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus tick-based debounce for the raw key level.
// level_o follows the synchronized key only after DEBOUNCE_MS consecutive mismatching ticks.
module key_debounce #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic key_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          key_s;

    assign key_s   = sync_q[1];
    assign level_o = level_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (key_s == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                level_d = key_s;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], key_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/morse_rx_ctrl.sv
// Morse digit receiver: classifies debounced key presses as dot/dash and decodes
// five-symbol groups into ASCII digits, keeping a three-character display history.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | key released, no character in progress, no timeout
//   ST_PRESS | key held, press length being measured
//   ST_GAP   | key released after a symbol, waiting for end-of-character
//   ST_OVF   | more than five symbols, waiting for quiet to emit '?'
module morse_rx_ctrl
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_MS = 10,
    parameter int DOT_MAX_MS  = 300,
    parameter int GAP_MS      = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1ms,
    input  logic        key,
    output logic        sym_valid,
    output logic        sym_long,
    output logic        char_valid,
    output logic [7:0]  char_code,
    output logic        char_err,
    output logic [23:0] disp_buf
);

    localparam int PW = $clog2(DOT_MAX_MS + 1);
    localparam int GW = $clog2(GAP_MS + 1);
    localparam logic [PW-1:0] PRESS_SAT = PW'(DOT_MAX_MS);
    localparam logic [GW-1:0] GAP_SAT   = GW'(GAP_MS);

    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    // Assert asynchronously, release two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_sync_n = rst_sync_q[1];

    logic deb_level;
    logic key_pressed;

    key_debounce #(
        .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_sync_n),
        .tick_i (tick_1ms),
        .key_i  (key),
        .level_o(deb_level)
    );

    assign key_pressed = ~deb_level;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] press_cnt_q, press_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [4:0]    sym_q, sym_d;
    logic [2:0]    sym_cnt_q, sym_cnt_d;
    logic          sym_valid_q, sym_valid_d;
    logic          sym_long_q, sym_long_d;
    logic          char_valid_q, char_valid_d;
    logic [7:0]    char_code_q, char_code_d;
    logic          char_err_q, char_err_d;
    logic [23:0]   disp_q, disp_d;

    char_dec_t     dec;
    logic          emit;
    logic [7:0]    emit_code;
    logic          emit_err;

    always_comb begin
        state_d      = state_q;
        press_cnt_d  = press_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        sym_d        = sym_q;
        sym_cnt_d    = sym_cnt_q;
        sym_valid_d  = 1'b0;
        sym_long_d   = sym_long_q;
        char_valid_d = 1'b0;
        char_code_d  = char_code_q;
        char_err_d   = char_err_q;
        disp_d       = disp_q;
        dec          = decode_char(sym_q, sym_cnt_q);
        emit         = 1'b0;
        emit_code    = CH_ERR;
        emit_err     = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (key_pressed) begin
                    state_d     = ST_PRESS;
                    press_cnt_d = '0;
                end
            end
            ST_PRESS: begin
                if (!key_pressed) begin
                    sym_valid_d = 1'b1;
                    sym_long_d  = (press_cnt_q >= PRESS_SAT);
                    gap_cnt_d   = '0;
                    if (sym_cnt_q == SYM_MAX) begin
                        state_d = ST_OVF;
                    end else begin
                        sym_d     = {sym_q[3:0], sym_long_d};
                        sym_cnt_d = sym_cnt_q + 3'd1;
                        state_d   = ST_GAP;
                    end
                end else if (tick_1ms && press_cnt_q != PRESS_SAT) begin
                    press_cnt_d = press_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (key_pressed) begin
                    state_d     = ST_PRESS;
                    press_cnt_d = '0;
                end else if (tick_1ms && gap_cnt_q != GAP_SAT) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    if (gap_cnt_d == GAP_SAT) begin
                        emit      = 1'b1;
                        emit_code = dec.code;
                        emit_err  = dec.err;
                    end
                end
            end
            ST_OVF: begin
                // Presses are swallowed but restart the quiet period.
                if (key_pressed) begin
                    gap_cnt_d = '0;
                end else if (tick_1ms && gap_cnt_q != GAP_SAT) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    if (gap_cnt_d == GAP_SAT) begin
                        emit = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit) begin
            char_valid_d = 1'b1;
            char_code_d  = emit_code;
            char_err_d   = emit_err;
            disp_d       = {disp_q[15:0], emit_code};
            sym_d        = '0;
            sym_cnt_d    = '0;
            state_d      = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q      <= ST_IDLE;
            press_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            sym_q        <= '0;
            sym_cnt_q    <= '0;
            sym_valid_q  <= 1'b0;
            sym_long_q   <= 1'b0;
            char_valid_q <= 1'b0;
            char_code_q  <= CH_BLANK;
            char_err_q   <= 1'b0;
            disp_q       <= {CH_BLANK, CH_BLANK, CH_BLANK};
        end else begin
            state_q      <= state_d;
            press_cnt_q  <= press_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            sym_q        <= sym_d;
            sym_cnt_q    <= sym_cnt_d;
            sym_valid_q  <= sym_valid_d;
            sym_long_q   <= sym_long_d;
            char_valid_q <= char_valid_d;
            char_code_q  <= char_code_d;
            char_err_q   <= char_err_d;
            disp_q       <= disp_d;
        end
    end

    assign sym_valid  = sym_valid_q;
    assign sym_long   = sym_long_q;
    assign char_valid = char_valid_q;
    assign char_code  = char_code_q;
    assign char_err   = char_err_q;
    assign disp_buf   = disp_q;

endmodule

// File: tb/tb_morse_rx_ctrl.sv
// Directed bench for morse_rx_ctrl: drives key sequences in whole-tick units and
// checks symbol/character pulses, decoded codes and the display history.
module tb_morse_rx_ctrl;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        tick_1ms = 1'b0;
    logic        key      = 1'b1;
    logic        sym_valid;
    logic        sym_long;
    logic        char_valid;
    logic [7:0]  char_code;
    logic        char_err;
    logic [23:0] disp_buf;

    int checks = 0;
    int errors = 0;

    int          sym_seen     = 0;
    int          dash_seen    = 0;
    int          char_seen    = 0;
    int          overlap_seen = 0;
    logic        last_long    = 1'b0;
    logic [7:0]  last_code    = 8'h00;
    logic        last_err     = 1'b0;
    logic [23:0] last_disp    = 24'h0;

    morse_rx_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1ms  (tick_1ms),
        .key       (key),
        .sym_valid (sym_valid),
        .sym_long  (sym_long),
        .char_valid(char_valid),
        .char_code (char_code),
        .char_err  (char_err),
        .disp_buf  (disp_buf)
    );

    always #5 clk = ~clk;

    // One-clock tick on every second clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1 tick_1ms = ~tick_1ms;
        end
    end

    always @(negedge clk) begin
        if (sym_valid === 1'b1) begin
            sym_seen++;
            last_long = sym_long;
            if (sym_long === 1'b1) dash_seen++;
        end
        if (char_valid === 1'b1) begin
            char_seen++;
            last_code = char_code;
            last_err  = char_err;
            last_disp = disp_buf;
        end
        if (sym_valid === 1'b1 && char_valid === 1'b1) overlap_seen++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (tick_1ms !== 1'b1);
        end
    endtask

    task automatic key_for(input logic lvl, input int n);
        key = lvl;
        wait_ticks(n);
        #2;
    endtask

    // pat: dash=1, first symbol in bit 4; ends with a long release that completes the character.
    task automatic send_char(input logic [4:0] pat);
        for (int i = 4; i >= 0; i--) begin
            key_for(1'b0, pat[i] ? 500 : 100);
            key_for(1'b1, (i == 0) ? 1100 : 200);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key   = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        checks++; if (char_code !== 8'h20) begin errors++; $display("FAIL reset_char_code: actual=%h required=20", char_code); end
        checks++; if (disp_buf !== 24'h202020) begin errors++; $display("FAIL reset_disp_buf: actual=%h required=202020", disp_buf); end
        checks++; if (char_err !== 1'b0) begin errors++; $display("FAIL reset_char_err: actual=%b required=0", char_err); end
        checks++; if (sym_valid !== 1'b0 || char_valid !== 1'b0 || sym_long !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: actual=%b%b%b required=000", sym_valid, char_valid, sym_long);
        end
        rst_n = 1'b1;
        wait_ticks(1);
        #2;
    endtask

    task automatic test_five_dots();
        int s0 = sym_seen; int d0 = dash_seen; int c0 = char_seen;
        send_char(5'b00000);
        checks++; if (sym_seen - s0 !== 5) begin errors++; $display("FAIL five_dots_syms: actual=%0d required=5", sym_seen - s0); end
        checks++; if (dash_seen - d0 !== 0) begin errors++; $display("FAIL five_dots_dashes: actual=%0d required=0", dash_seen - d0); end
        checks++; if (char_seen - c0 !== 1) begin errors++; $display("FAIL five_dots_chars: actual=%0d required=1", char_seen - c0); end
        checks++; if (last_code !== 8'h35 || last_err !== 1'b0) begin errors++; $display("FAIL five_dots_code: actual=%h/%b required=35/0", last_code, last_err); end
        checks++; if (last_disp !== 24'h202035) begin errors++; $display("FAIL five_dots_disp: actual=%h required=202035", last_disp); end
        checks++; if (char_code !== 8'h35) begin errors++; $display("FAIL five_dots_hold: actual=%h required=35", char_code); end
    endtask

    task automatic test_one_zero();
        int d0 = dash_seen; int c0 = char_seen;
        send_char(5'b01111);
        checks++; if (last_code !== 8'h31 || last_err !== 1'b0) begin errors++; $display("FAIL one_code: actual=%h/%b required=31/0", last_code, last_err); end
        checks++; if (dash_seen - d0 !== 4) begin errors++; $display("FAIL one_dashes: actual=%0d required=4", dash_seen - d0); end
        send_char(5'b11111);
        checks++; if (last_code !== 8'h30 || last_err !== 1'b0) begin errors++; $display("FAIL zero_code: actual=%h/%b required=30/0", last_code, last_err); end
        checks++; if (last_disp !== 24'h353130) begin errors++; $display("FAIL one_zero_disp: actual=%h required=353130", last_disp); end
        checks++; if (char_seen - c0 !== 2) begin errors++; $display("FAIL one_zero_chars: actual=%0d required=2", char_seen - c0); end
    endtask

    task automatic test_short_char();
        int s0 = sym_seen; int c0 = char_seen;
        repeat (2) begin key_for(1'b0, 100); key_for(1'b1, 200); end
        key_for(1'b0, 100);
        key_for(1'b1, 1100);
        checks++; if (sym_seen - s0 !== 3) begin errors++; $display("FAIL short_syms: actual=%0d required=3", sym_seen - s0); end
        checks++; if (char_seen - c0 !== 1) begin errors++; $display("FAIL short_chars: actual=%0d required=1", char_seen - c0); end
        checks++; if (last_code !== 8'h3F || last_err !== 1'b1) begin errors++; $display("FAIL short_code: actual=%h/%b required=3f/1", last_code, last_err); end
        checks++; if (last_disp !== 24'h31303F) begin errors++; $display("FAIL short_disp: actual=%h required=31303f", last_disp); end
    endtask

    task automatic test_overflow();
        int s0 = sym_seen; int c0 = char_seen;
        repeat (5) begin key_for(1'b0, 100); key_for(1'b1, 200); end
        key_for(1'b0, 100);
        key_for(1'b1, 500);
        checks++; if (char_seen !== c0) begin errors++; $display("FAIL ovf_early: actual=%0d required=%0d", char_seen, c0); end
        key_for(1'b0, 100);
        key_for(1'b1, 1005);
        checks++; if (char_seen !== c0) begin errors++; $display("FAIL ovf_quiet_restart: actual=%0d required=%0d", char_seen, c0); end
        key_for(1'b1, 20);
        checks++; if (char_seen - c0 !== 1) begin errors++; $display("FAIL ovf_chars: actual=%0d required=1", char_seen - c0); end
        checks++; if (sym_seen - s0 !== 6) begin errors++; $display("FAIL ovf_syms: actual=%0d required=6", sym_seen - s0); end
        checks++; if (last_code !== 8'h3F || last_err !== 1'b1) begin errors++; $display("FAIL ovf_code: actual=%h/%b required=3f/1", last_code, last_err); end
        checks++; if (last_disp !== 24'h303F3F) begin errors++; $display("FAIL ovf_disp: actual=%h required=303f3f", last_disp); end
    endtask

    task automatic test_dot_dash_boundary();
        int s0 = sym_seen; int d0 = dash_seen;
        key_for(1'b0, 299);
        key_for(1'b1, 200);
        checks++; if (sym_seen - s0 !== 1 || last_long !== 1'b0) begin
            errors++; $display("FAIL press_299: actual=%0d/%b required=1/0", sym_seen - s0, last_long);
        end
        key_for(1'b0, 300);
        key_for(1'b1, 1100);
        checks++; if (sym_seen - s0 !== 2 || last_long !== 1'b1) begin
            errors++; $display("FAIL press_300: actual=%0d/%b required=2/1", sym_seen - s0, last_long);
        end
        checks++; if (dash_seen - d0 !== 1) begin errors++; $display("FAIL boundary_dashes: actual=%0d required=1", dash_seen - d0); end
        checks++; if (last_code !== 8'h3F || last_err !== 1'b1 || last_disp !== 24'h3F3F3F) begin
            errors++; $display("FAIL boundary_char: actual=%h/%b/%h required=3f/1/3f3f3f", last_code, last_err, last_disp);
        end
    endtask

    task automatic test_glitch_and_reset();
        int s0 = sym_seen; int c0;
        key_for(1'b0, 5);
        key_for(1'b1, 50);
        checks++; if (sym_seen !== s0) begin errors++; $display("FAIL glitch_syms: actual=%0d required=%0d", sym_seen, s0); end
        repeat (2) begin key_for(1'b0, 100); key_for(1'b1, 200); end
        checks++; if (sym_seen - s0 !== 2) begin errors++; $display("FAIL pre_reset_syms: actual=%0d required=2", sym_seen - s0); end
        rst_n = 1'b0;
        #1;
        checks++; if (disp_buf !== 24'h202020 || char_code !== 8'h20) begin
            errors++; $display("FAIL async_reset: actual=%h/%h required=202020/20", disp_buf, char_code);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_ticks(1);
        #2;
        c0 = char_seen;
        key_for(1'b1, 1100);
        checks++; if (char_seen !== c0) begin errors++; $display("FAIL reset_discard: actual=%0d required=%0d", char_seen, c0); end
        send_char(5'b11110);
        checks++; if (last_code !== 8'h39 || last_err !== 1'b0) begin errors++; $display("FAIL nine_code: actual=%h/%b required=39/0", last_code, last_err); end
        checks++; if (last_disp !== 24'h202039) begin errors++; $display("FAIL nine_disp: actual=%h required=202039", last_disp); end
    endtask

    task automatic test_idle_quiet();
        int c0 = char_seen;
        key_for(1'b1, 1500);
        checks++; if (char_seen !== c0) begin errors++; $display("FAIL idle_timeout: actual=%0d required=%0d", char_seen, c0); end
        checks++; if (char_code !== 8'h39 || disp_buf !== 24'h202039) begin
            errors++; $display("FAIL idle_hold: actual=%h/%h required=39/202039", char_code, disp_buf);
        end
    endtask

    task automatic test_no_overlap();
        checks++; if (overlap_seen !== 0) begin errors++; $display("FAIL pulse_overlap: actual=%0d required=0", overlap_seen); end
    endtask

    initial begin
        test_reset();
        test_five_dots();
        test_one_zero();
        test_short_char();
        test_overflow();
        test_dot_dash_boundary();
        test_glitch_and_reset();
        test_idle_quiet();
        test_no_overlap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
